// File: rtl/avalon_sw_accumulator_pkg.sv
// Shared constants for the switch accumulator peripheral.
// Register map, bit positions and accumulator width.
package avalon_sw_accumulator_pkg;

  localparam logic [1:0] ADDR_ACC    = 2'd0;
  localparam logic [1:0] ADDR_SW     = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_IRQ_EN = 0;
  localparam int STAT_OVF    = 0;
  localparam int STAT_PEND   = 1;

  localparam int ACC_W = 16;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low key.
// Emits a one-cycle pulse on each debounced press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed_n,
  output logic press_pulse
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          key_s1;
  logic          key_s2;
  logic          deb_q;
  logic          deb_d1;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; idles released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Stability counter; debounced state flips after a full run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      deb_q <= 1'b1;
    end else if (key_s2 == deb_q) begin
      cnt   <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      deb_q <= key_s2;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Registered falling-edge detect of the debounced key
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d1      <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      deb_d1      <= deb_q;
      press_pulse <= deb_d1 & ~deb_q;
    end
  end

  assign pressed_n = deb_q;

endmodule

// File: rtl/avalon_sw_accumulator.sv
// Avalon-MM switch accumulator with LED output and
// per-press interrupt.
module avalon_sw_accumulator
  import avalon_sw_accumulator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            avs_chipselect,
  input  logic [1:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [3:0]      avs_byteenable,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  input  logic [SW_W-1:0] sw,
  input  logic            accumulate_n,
  output logic [SW_W-1:0] led,
  output logic            irq
);

  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_s2;
  logic [ACC_W-1:0] acc_q;
  logic             irq_en_q;
  logic             ovf_q;
  logic             pend_q;
  logic             press;
  logic             pressed_n;

  logic             wr;
  logic             rd;
  logic             acc_wr;
  logic             ctrl_wr;
  logic             stat_wr;
  logic [ACC_W-1:0] acc_bus;
  logic [ACC_W:0]   acc_sum;
  logic             ovf_set;
  logic             ovf_clr;
  logic             pend_clr;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (accumulate_n),
    .pressed_n  (pressed_n),
    .press_pulse(press)
  );

  // Two-flop synchronizer for the switches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  assign wr      = avs_chipselect & avs_write;
  assign rd      = avs_chipselect & avs_read;
  assign acc_wr  = wr & (avs_address == ADDR_ACC);
  assign ctrl_wr = wr & (avs_address == ADDR_CTRL);
  assign stat_wr = wr & (avs_address == ADDR_STATUS);

  assign acc_bus = {
    avs_byteenable[1] ? avs_writedata[15:8] : acc_q[15:8],
    avs_byteenable[0] ? avs_writedata[7:0]  : acc_q[7:0]
  };

  assign acc_sum = {1'b0, acc_q}
                 + {{(ACC_W + 1 - SW_W){1'b0}}, sw_s2};

  // A bus write to ACC discards a coincident press add
  assign ovf_set  = press & ~acc_wr & acc_sum[ACC_W];
  assign ovf_clr  = stat_wr & avs_byteenable[0]
                  & avs_writedata[STAT_OVF];
  assign pend_clr = stat_wr & avs_byteenable[0]
                  & avs_writedata[STAT_PEND];

  // Accumulator: bus write has priority over press add
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (acc_wr) begin
      acc_q <= acc_bus;
    end else if (press) begin
      acc_q <= acc_sum[ACC_W-1:0];
    end
  end

  // Control and write-1-to-clear status; set beats clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (ctrl_wr && avs_byteenable[0])
        irq_en_q <= avs_writedata[CTRL_IRQ_EN];
      ovf_q  <= ovf_set | (ovf_q & ~ovf_clr);
      pend_q <= press | (pend_q & ~pend_clr);
    end
  end

  // Read data select
  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      ADDR_ACC:    rd_mux = 32'(acc_q);
      ADDR_SW:     rd_mux = 32'(sw_s2);
      ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rd_mux[STAT_OVF]  = ovf_q;
        rd_mux[STAT_PEND] = pend_q;
      end
      default:     rd_mux = '0;
    endcase
  end

  // Registered read port, holds when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      avs_readdata <= '0;
    else if (rd)
      avs_readdata <= rd_mux;
  end

  assign led = acc_q[SW_W-1:0];
  assign irq = pend_q & irq_en_q;

  assign unused_ok = ^{avs_writedata[31:16],
                       avs_byteenable[3:2],
                       pressed_n};

endmodule
